// File: rtl/wb_stage_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : wb_stage_pipe
//  Description : Registered writeback stage with RF write hold, PC redirect,
//                shadow squash and retire counting.
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_stage_pipe #(
  parameter int DATA_W   = 16,
  parameter int NREGS    = 8,
  parameter int LINK_REG = 7,
  parameter int SHADOW   = 2,
  parameter int RET_W    = 32,
  localparam int AW      = (NREGS > 1) ? $clog2(NREGS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       in_ir,
  input  logic [DATA_W-1:0] in_alu,
  input  logic [DATA_W-1:0] in_mem,
  input  logic [DATA_W-1:0] in_pc_next,
  input  logic              in_z,
  input  logic              in_n,
  output logic              rf_we,
  output logic              rf_hi_only,
  output logic [AW-1:0]     rf_addr,
  output logic [DATA_W-1:0] rf_data,
  input  logic              rf_ack,
  output logic              pc_redirect,
  output logic [DATA_W-1:0] pc_target,
  output logic              squash_active,
  output logic [RET_W-1:0]  retire_count
);

  localparam int SW = (SHADOW > 0) ? $clog2(SHADOW + 1) : 1;

  localparam logic [3:0] OP_MV   = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_LD   = 4'd4;
  localparam logic [3:0] OP_MVHI = 4'd6;
  localparam logic [3:0] OP_J    = 4'd8;
  localparam logic [3:0] OP_JZ   = 4'd9;
  localparam logic [3:0] OP_JN   = 4'd10;
  localparam logic [3:0] OP_CALL = 4'd12;

  logic              rf_we_q, rf_we_d;
  logic              rf_hi_q, rf_hi_d;
  logic [AW-1:0]     rf_addr_q, rf_addr_d;
  logic [DATA_W-1:0] rf_data_q, rf_data_d;
  logic              redir_q, redir_d;
  logic [DATA_W-1:0] target_q, target_d;
  logic [SW-1:0]     sq_q, sq_d;
  logic [RET_W-1:0]  retire_q, retire_d;

  logic              w_accept, w_squash, w_live;
  logic              w_wr, w_hi, w_taken;
  logic [AW-1:0]     w_waddr;
  logic [DATA_W-1:0] w_wdata;
  logic              w_unused_ir;

  // Immediate-form bit and the upper IR byte are consumed upstream only.
  assign w_unused_ir = ^{in_ir[15:8], in_ir[4]};

  assign in_ready = !reset && (!rf_we_q || rf_ack);
  assign w_accept = in_valid && in_ready;
  assign w_squash = w_accept && (sq_q != '0);
  assign w_live   = w_accept && (sq_q == '0);

  always_comb begin
    w_wr    = 1'b0;
    w_hi    = 1'b0;
    w_taken = 1'b0;
    w_waddr = AW'(in_ir[7:5]);
    w_wdata = in_alu;
    case (in_ir[3:0])
      OP_MV, OP_ADD, OP_SUB: w_wr = 1'b1;
      OP_LD: begin
        w_wr    = 1'b1;
        w_wdata = in_mem;
      end
      OP_MVHI: begin
        w_wr = 1'b1;
        w_hi = 1'b1;
      end
      OP_J:  w_taken = 1'b1;
      OP_JZ: w_taken = in_z;
      OP_JN: w_taken = in_n;
      OP_CALL: begin
        w_taken = 1'b1;
        w_wr    = 1'b1;
        w_waddr = AW'(LINK_REG);
        w_wdata = in_pc_next;
      end
      default: ;
    endcase
  end

  always_comb begin
    rf_we_d   = rf_we_q;
    rf_hi_d   = rf_hi_q;
    rf_addr_d = rf_addr_q;
    rf_data_d = rf_data_q;
    if (rf_we_q && rf_ack) begin
      rf_we_d = 1'b0;
    end
    // A new write may land in the same cycle the previous one is acknowledged.
    if (w_live && w_wr) begin
      rf_we_d   = 1'b1;
      rf_hi_d   = w_hi;
      rf_addr_d = w_waddr;
      rf_data_d = w_wdata;
    end

    redir_d  = w_live && w_taken;
    target_d = (w_live && w_taken) ? in_alu : target_q;

    sq_d = sq_q;
    if (w_live && w_taken) begin
      sq_d = SW'(SHADOW);
    end else if (w_squash) begin
      sq_d = sq_q - SW'(1);
    end

    retire_d = w_live ? (retire_q + RET_W'(1)) : retire_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rf_we_q   <= 1'b0;
      rf_hi_q   <= 1'b0;
      rf_addr_q <= '0;
      rf_data_q <= '0;
      redir_q   <= 1'b0;
      target_q  <= '0;
      sq_q      <= '0;
      retire_q  <= '0;
    end else begin
      rf_we_q   <= rf_we_d;
      rf_hi_q   <= rf_hi_d;
      rf_addr_q <= rf_addr_d;
      rf_data_q <= rf_data_d;
      redir_q   <= redir_d;
      target_q  <= target_d;
      sq_q      <= sq_d;
      retire_q  <= retire_d;
    end
  end

  assign rf_we         = rf_we_q;
  assign rf_hi_only    = rf_hi_q;
  assign rf_addr       = rf_addr_q;
  assign rf_data       = rf_data_q;
  assign pc_redirect   = redir_q;
  assign pc_target     = target_q;
  assign squash_active = (sq_q != '0);
  assign retire_count  = retire_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_stage_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_wb_stage_pipe
//  Description : Scoreboard bench for wb_stage_pipe (DATA_W=32 instance).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_stage_pipe;

  localparam int DW   = 32;
  localparam int SH   = 2;
  localparam int LINK = 7;
  localparam int RW   = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [15:0]   in_ir = '0;
  logic [DW-1:0] in_alu = '0, in_mem = '0, in_pc_next = '0;
  logic          in_z = 1'b0, in_n = 1'b0;
  logic          rf_we, rf_hi_only;
  logic [2:0]    rf_addr;
  logic [DW-1:0] rf_data;
  logic          rf_ack = 1'b0;
  logic          pc_redirect;
  logic [DW-1:0] pc_target;
  logic          squash_active;
  logic [RW-1:0] retire_count;

  always #5 clk = ~clk;

  wb_stage_pipe #(
    .DATA_W(DW), .NREGS(8), .LINK_REG(LINK), .SHADOW(SH), .RET_W(RW)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_ir(in_ir),
    .in_alu(in_alu), .in_mem(in_mem), .in_pc_next(in_pc_next),
    .in_z(in_z), .in_n(in_n),
    .rf_we(rf_we), .rf_hi_only(rf_hi_only), .rf_addr(rf_addr),
    .rf_data(rf_data), .rf_ack(rf_ack),
    .pc_redirect(pc_redirect), .pc_target(pc_target),
    .squash_active(squash_active), .retire_count(retire_count)
  );

  typedef struct {
    logic [2:0]    addr;
    logic [DW-1:0] data;
    logic          hi;
  } wr_t;

  wr_t           wq[$];
  logic [DW-1:0] rq[$];
  int            exp_sq = 0;
  logic          exp_pending = 1'b0;
  logic [RW-1:0] exp_retire = '0;
  int            checks = 0;
  int            failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp_v, $time);
    end
  endtask

  // Architectural meaning of one instruction, straight from the opcode table.
  task automatic ref_decode(input logic [15:0] ir, input logic z, input logic n,
                            input logic [DW-1:0] alu, input logic [DW-1:0] mem,
                            input logic [DW-1:0] pcn,
                            output logic wr, output wr_t w, output logic tk);
    int op;
    op = int'(ir[3:0]);
    wr = 1'b0; tk = 1'b0;
    w.addr = ir[7:5]; w.data = alu; w.hi = 1'b0;
    case (op)
      0, 1, 2: wr = 1'b1;
      4:  begin wr = 1'b1; w.data = mem; end
      6:  begin wr = 1'b1; w.hi = 1'b1; end
      8:  tk = 1'b1;
      9:  tk = z;
      10: tk = n;
      12: begin tk = 1'b1; wr = 1'b1; w.addr = 3'(LINK); w.data = pcn; end
      default: ;
    endcase
  endtask

  // Drive one cycle of inputs, then advance the reference model to the
  // state expected after the coming clock edge.
  task automatic step(input logic rst, input logic v, input logic [15:0] ir,
                      input logic [DW-1:0] alu, input logic [DW-1:0] mem,
                      input logic [DW-1:0] pcn, input logic z, input logic n,
                      input logic ack);
    logic acc, np, wr, tk;
    wr_t  w;
    @(posedge clk);
    #1;
    reset = rst; in_valid = v; in_ir = ir; in_alu = alu; in_mem = mem;
    in_pc_next = pcn; in_z = z; in_n = n; rf_ack = ack;
    #3;
    if (rst) begin
      wq.delete(); rq.delete();
      exp_sq = 0; exp_pending = 1'b0; exp_retire = '0;
    end else begin
      acc = v && (!exp_pending || ack);
      np  = exp_pending && !ack;
      if (acc) begin
        if (exp_sq > 0) begin
          exp_sq--;
        end else begin
          exp_retire++;
          ref_decode(ir, z, n, alu, mem, pcn, wr, w, tk);
          if (wr) begin wq.push_back(w); np = 1'b1; end
          if (tk) begin rq.push_back(alu); exp_sq = SH; end
        end
      end
      exp_pending = np;
    end
  endtask

  task automatic idle(input int cycles, input logic ack);
    for (int i = 0; i < cycles; i++) step(1'b0, 1'b0, 16'h0, '0, '0, '0, 1'b0, 1'b0, ack);
  endtask

  // Monitor: compares DUT outputs against the scoreboard every cycle.
  initial begin
    wr_t           hw;
    logic [DW-1:0] tgt;
    forever begin
      @(posedge clk);
      #2;
      chk("in_ready", {63'd0, in_ready}, {63'd0, !reset && (!exp_pending || rf_ack)});
      chk("rf_we", {63'd0, rf_we}, {63'd0, exp_pending});
      if (rf_we && exp_pending) begin
        if (wq.size() == 0) begin
          chk("write_queue_empty", 64'd0, 64'd1);
        end else begin
          hw = wq[0];
          chk("rf_addr", {61'd0, rf_addr}, {61'd0, hw.addr});
          chk("rf_data", {32'd0, rf_data}, {32'd0, hw.data});
          chk("rf_hi_only", {63'd0, rf_hi_only}, {63'd0, hw.hi});
          if (rf_ack) void'(wq.pop_front());
        end
      end
      chk("pc_redirect", {63'd0, pc_redirect}, {63'd0, rq.size() != 0});
      if (rq.size() != 0) begin
        tgt = rq.pop_front();
        if (pc_redirect) chk("pc_target", {32'd0, pc_target}, {32'd0, tgt});
      end
      chk("squash_active", {63'd0, squash_active}, {63'd0, exp_sq != 0});
      chk("retire_count", {32'd0, retire_count}, {32'd0, exp_retire});
    end
  end

  initial begin
    step(1'b1, 1'b0, 16'h0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 16'h0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    chk("reset_rf_addr", {61'd0, rf_addr}, 64'd0);
    chk("reset_rf_data", {32'd0, rf_data}, 64'd0);
    chk("reset_pc_target", {32'd0, pc_target}, 64'd0);
    idle(1, 1'b1);

    // ADD R3
    step(1'b0, 1'b1, 16'h0061, 32'h1234, '0, '0, 1'b0, 1'b0, 1'b1);
    idle(2, 1'b1);

    // LD R2 held for four cycles; an ADD R1 waits for the ack cycle
    step(1'b0, 1'b1, 16'h0044, 32'h5555, 32'hBEEF, '0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b1, 16'h0021, 32'h0777, '0, '0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 16'h0021, 32'h0777, '0, '0, 1'b0, 1'b0, 1'b1);
    idle(2, 1'b1);

    // JZ not taken, then taken
    step(1'b0, 1'b1, 16'h0009, 32'h0030, '0, '0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 16'h0009, 32'h0040, '0, '0, 1'b1, 1'b0, 1'b1);
    idle(3, 1'b1);

    // CALL then three ADDs: two squashed, third writes
    step(1'b0, 1'b1, 16'h000C, 32'h0100, '0, 32'h0021, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b1, 16'h0021, 32'h1000 + i, '0, '0, 1'b0, 1'b0, 1'b1);
    idle(2, 1'b1);

    // Reset while a write is pending and the squash counter is loaded
    step(1'b0, 1'b1, 16'h000C, 32'h0200, '0, 32'h0033, 1'b0, 1'b0, 1'b0);
    idle(1, 1'b0);
    step(1'b1, 1'b0, 16'h0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    idle(1, 1'b1);
    step(1'b0, 1'b1, 16'h0041, 32'h0ABC, '0, '0, 1'b0, 1'b0, 1'b1);
    idle(2, 1'b1);

    // MVHI R1 on a 32-bit datapath, then back-to-back writes
    step(1'b0, 1'b1, 16'h0026, 32'hDEADBEEF, '0, '0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++)
      step(1'b0, 1'b1, 16'((i << 5) | 1), 32'hA000 + i, '0, '0, 1'b0, 1'b0, 1'b1);
    idle(2, 1'b1);

    // Randomised traffic with random backpressure and occasional reset
    for (int i = 0; i < 800; i++) begin
      step($urandom_range(0, 99) == 0,
           $urandom_range(0, 3) != 0,
           16'($urandom),
           DW'($urandom), DW'($urandom), DW'($urandom),
           1'($urandom), 1'($urandom),
           $urandom_range(0, 3) != 0);
    end
    idle(6, 1'b1);
    chk("drain_writes", 64'(wq.size()), 64'd0);
    chk("drain_redirects", 64'(rq.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
